prefetch_fetch: RTL

//  Parametrised instruction prefetch unit between the core's IF stage and an instruction memory port.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/prefetch_fetch.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction prefetch unit.
// Misaligned-redirect flagging in prefetch_fetch is enabled by defining FETCH_ALIGN_CHK_EN.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
    } fetch_entry_t;

    localparam int WORD_BYTES = 4;

    function automatic int fetch_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head is read straight from storage, so a push is visible next cycle.
// Push while full is dropped unless a pop happens in the same cycle; flush overrides push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  T                             data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output T                             data_o,
    output logic [fetch_ptr_w(DEPTH):0]  count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int PW = fetch_ptr_w(DEPTH);

    T            mem_q [DEPTH];
    T            mem_d [DEPTH];
    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    // The extra pointer bit tells a full buffer apart from an empty one.
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        data_o = '0;
        if (!empty_o) data_o = mem_q[rd_ptr_q[PW-1:0]];
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[PW-1:0]] = data_i;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/prefetch_fetch.sv
// Instruction prefetch: credit-limited req/gnt/rvalid fetch into an in-order buffer, flushed on redirect.
// Response-to-valid_o 1 cycle; stall_i holds the head; FETCH_ALIGN_CHK_EN adds the misalign err_o flag.
module prefetch_fetch
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        err_o,
    input  logic        stall_i,
    input  logic        new_pc_i,
    input  logic [31:0] pc_i,
    output logic        req_o,
    output logic [31:0] addr_o,
    input  logic        gnt_i,
    input  logic        rvalid_i,
    input  logic [31:0] rdata_i
);
    localparam int          CW      = fetch_ptr_w(DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

    logic [31:0]   fetch_addr_q, fetch_addr_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] fifo_count, pcq_count;
    logic          fifo_full, fifo_empty, pcq_full, pcq_empty;
    logic [31:0]   pcq_pc;
    logic          grant, consume, resp_keep, entry_err;
    logic          unused_sig;
    fetch_entry_t  push_entry, head_entry;

    // Buffered words plus in-flight requests never exceed DEPTH, so every response has a slot.
    assign req_o     = !rst_i && !new_pc_i && (({1'b0, fifo_count} + {1'b0, outstanding_q}) < CREDITS);
    assign addr_o    = fetch_addr_q;
    assign grant     = req_o && gnt_i;
    assign consume   = valid_o && !stall_i;
    assign resp_keep = rvalid_i && (discard_q == '0);

    assign valid_o    = !fifo_empty;
    assign instr_o    = head_entry.instr;
    assign pc_o       = head_entry.pc;
    assign push_entry = '{instr: rdata_i, pc: pcq_pc, err: entry_err};

    always_comb begin
        fetch_addr_d  = fetch_addr_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CW'(grant) - CW'(rvalid_i);
        if (new_pc_i) begin
            // Everything still in flight after this edge belongs to the old stream.
            discard_d    = outstanding_q - CW'(rvalid_i);
            fetch_addr_d = {pc_i[31:2], 2'b00};
        end else begin
            if (rvalid_i && discard_q != '0) discard_d = discard_q - 1'b1;
            if (grant) fetch_addr_d = fetch_addr_q + 32'(WORD_BYTES);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_addr_q  <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_addr_q  <= fetch_addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // Request addresses wait here until their response returns; discarded responses pop too.
    fetch_fifo #(.DEPTH(DEPTH), .T(logic [31:0])) u_pc_queue (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (grant),
        .data_i  (fetch_addr_q),
        .pop_i   (rvalid_i),
        .flush_i (1'b0),
        .data_o  (pcq_pc),
        .count_o (pcq_count),
        .full_o  (pcq_full),
        .empty_o (pcq_empty)
    );

    fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_instr_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (resp_keep),
        .data_i  (push_entry),
        .pop_i   (consume),
        .flush_i (new_pc_i),
        .data_o  (head_entry),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef FETCH_ALIGN_CHK_EN
    logic misalign_q, misalign_d;

    // The flag rides on the first word kept after the redirect, so it clears when that word is consumed.
    always_comb begin
        misalign_d = misalign_q;
        if (new_pc_i) misalign_d = (pc_i[1:0] != 2'b00);
        else if (resp_keep) misalign_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) misalign_q <= 1'b0;
        else       misalign_q <= misalign_d;
    end

    assign entry_err  = misalign_q;
    assign err_o      = head_entry.err;
    assign unused_sig = ^{fifo_full, pcq_full, pcq_empty, pcq_count};
`else
    assign entry_err  = 1'b0;
    assign err_o      = 1'b0;
    assign unused_sig = ^{fifo_full, pcq_full, pcq_empty, pcq_count, head_entry.err, pc_i[1:0]};
`endif

endmodule
